// File: rtl/popcount_pkg.sv
// Shared types and helpers for the popcount accumulator.
// The optional POPCOUNT_THRESH_EN majority output is configured in popcount_accum.
package popcount_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bits needed to hold any count from 0 up to total_bits inclusive
  function automatic int unsigned cnt_width(input int unsigned total_bits);
    return $clog2(total_bits + 1);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of one beat, built as a pairwise adder tree.
module popcount_tree #(
  parameter  int unsigned DW = 64,
  localparam int unsigned PW = $clog2(DW + 1)
) (
  input  logic [DW-1:0] in_data,
  output logic [PW-1:0] out_count
);

  // Stride-doubling reduction: each pass halves the number of live partial sums
  always_comb begin
    logic [PW-1:0] node [DW];
    for (int i = 0; i < int'(DW); i++) begin
      node[i] = PW'(in_data[i]);
    end
    for (int s = 1; s < int'(DW); s = s * 2) begin
      for (int i = 0; i + s < int'(DW); i = i + 2 * s) begin
        node[i] = node[i] + node[i + s];
      end
    end
    out_count = node[0];
  end

endmodule

// File: rtl/popcount_accum.sv
// Streaming popcount accumulator: sums ones over multi-beat hypervectors.
// Define POPCOUNT_THRESH_EN to add the thresh input and out_major output.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter  int unsigned DW    = 64,
  parameter  int unsigned NBEAT = 16,
  localparam int unsigned CW    = cnt_width(DW * NBEAT),
  localparam int unsigned BW    = $clog2(NBEAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic [BW-1:0] out_beats,
  output logic          out_trunc
`ifdef POPCOUNT_THRESH_EN
  ,
  input  logic [CW-1:0] thresh,
  output logic          out_major
`endif
);

  localparam int unsigned PW = $clog2(DW + 1);

  state_t        r_state;
  logic [CW-1:0] r_acc;
  logic [BW-1:0] r_beats;
  logic          r_out_valid;
  logic [CW-1:0] r_out_count;
  logic [BW-1:0] r_out_beats;
  logic          r_out_trunc;

  logic [PW-1:0] w_pc;
  logic          w_accept;
  logic          w_first;
  logic          w_close;
  logic [CW-1:0] w_sum;
  logic [BW-1:0] w_nbeats;

  popcount_tree #(.DW(DW)) u_tree (
    .in_data  (in_data),
    .out_count(w_pc)
  );

  assign in_ready = (r_state == ACC) || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_beats == '0);
  assign w_sum    = (w_first ? '0 : r_acc) + CW'(w_pc);
  assign w_nbeats = r_beats + BW'(1);
  assign w_close  = in_last || (w_nbeats == BW'(NBEAT));

`ifdef POPCOUNT_THRESH_EN
  logic r_out_major;
  assign out_major = r_out_major;
`endif

  // Closing beat always lands in HOLD, even when the previous result drains in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_beats     <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_beats <= '0;
      r_out_trunc <= 1'b0;
`ifdef POPCOUNT_THRESH_EN
      r_out_major <= 1'b0;
`endif
    end else begin
      if ((r_state == HOLD) && out_ready) begin
        r_state     <= ACC;
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_close) begin
          r_state     <= HOLD;
          r_out_valid <= 1'b1;
          r_out_count <= w_sum;
          r_out_beats <= w_nbeats;
          r_out_trunc <= !in_last;
`ifdef POPCOUNT_THRESH_EN
          r_out_major <= (w_sum >= thresh);
`endif
          r_acc       <= '0;
          r_beats     <= '0;
        end else begin
          r_acc   <= w_sum;
          r_beats <= w_nbeats;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_beats = r_out_beats;
  assign out_trunc = r_out_trunc;

endmodule
